// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for a five-stage in-order pipeline.
// Generates PC / pipeline-register load enables and bubble (flush) requests
// from load-use hazards, taken branches and data-memory wait states, and
// keeps saturating event counters for load-use stalls, flushes and wait cycles.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             IF_IDwrite_o,
  output logic             ID_EXwrite_o,
  output logic             EX_MEMwrite_o,
  output logic             IF_IDflush_o,
  output logic             ID_EXflush_o,
  output logic             EX_MEMflush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] wait_cnt_o
);

  // Controller states. Encoding 3 is never entered; it is treated as RUN.
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  // Counter slots inside the packed counter bank.
  localparam int CNT_LU    = 0;
  localparam int CNT_FLUSH = 1;
  localparam int CNT_WAIT  = 2;
  localparam int N_CNT     = 3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] state_q, state_d;
  logic       pend_q, pend_d;

  logic lu_hazard;

  logic pc_we;
  logic ifid_we;
  logic idex_we;
  logic exmem_we;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;

  logic [N_CNT-1:0]            cnt_inc;
  logic [N_CNT-1:0][CNT_W-1:0] cnt_q;
  logic [N_CNT-1:0][CNT_W-1:0] cnt_d;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // $0 is hard-wired to zero, so a load targeting it never creates a dependence.
  always_comb begin
    lu_hazard = ex_memread_i && (ex_rt_i != 5'd0) &&
                ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  end

  // Next-state, pending-branch and zero-latency enable/flush decode.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    exmem_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    cnt_inc     = '0;

    case (state_q)
      ST_MEM_WAIT: begin
        // Whole pipeline frozen, including the cycle in which memory releases.
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        cnt_inc[CNT_WAIT] = 1'b1;
        // A branch resolved while frozen must not be lost: remember it.
        pend_d = pend_q | branch_taken_i;
        if (!mem_busy_i) begin
          state_d = (pend_q || branch_taken_i) ? ST_FLUSH : ST_RUN;
        end
      end

      ST_FLUSH: begin
        // Replay the deferred branch redirect. A memory stall raised here is
        // ignored for now and picked up again by the following RUN cycle.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        cnt_inc[CNT_FLUSH] = 1'b1;
        pend_d  = 1'b0;
        state_d = ST_RUN;
      end

      default: begin
        // RUN (and the unused encoding, which is decoded as RUN and left at once).
        state_d = ST_RUN;
        if (mem_busy_i) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_we  = 1'b0;
          exmem_we = 1'b0;
          pend_d   = branch_taken_i;
          state_d  = ST_MEM_WAIT;
        end else if (branch_taken_i) begin
          // Wrong-path instructions are squashed; a load-use stall on a
          // squashed instruction is meaningless, so LU is not considered.
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          cnt_inc[CNT_FLUSH] = 1'b1;
        end else if (lu_hazard) begin
          // Hold PC and IF/ID, insert one bubble into ID/EX.
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
          cnt_inc[CNT_LU] = 1'b1;
        end
        if (state_q != ST_RUN) begin
          state_d = ST_RUN;
        end
      end
    endcase

    // While reset is held nothing in the pipeline may load or be flushed.
    if (!rst_i) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  // Saturating increment for each event counter.
  generate
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
      assign cnt_d[gi] = (cnt_inc[gi] && (cnt_q[gi] != CNT_MAX)) ?
                         (cnt_q[gi] + CNT_ONE) : cnt_q[gi];
    end
  endgenerate

  // State, pending-branch flag and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_write_o    = pc_we;
  assign IF_IDwrite_o  = ifid_we;
  assign ID_EXwrite_o  = idex_we;
  assign EX_MEMwrite_o = exmem_we;
  assign IF_IDflush_o  = ifid_flush;
  assign ID_EXflush_o  = idex_flush;
  assign EX_MEMflush_o = exmem_flush;
  assign state_o       = state_q;
  assign lu_cnt_o      = cnt_q[CNT_LU];
  assign flush_cnt_o   = cnt_q[CNT_FLUSH];
  assign wait_cnt_o    = cnt_q[CNT_WAIT];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// compared against a behavioural model of the stall/flush rules.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, br, busy;

  logic a_pc, a_ifw, a_idw, a_exw, a_iff, a_idf, a_exf;
  logic [1:0]  a_st;
  logic [15:0] a_lu, a_fl, a_wt;
  logic b_pc, b_ifw, b_idw, b_exw, b_iff, b_idf, b_exf;
  logic [1:0]  b_st;
  logic [1:0]  b_lu, b_fl, b_wt;

  logic [6:0] outs_a, outs_b;
  assign outs_a = {a_pc, a_ifw, a_idw, a_exw, a_iff, a_idf, a_exf};
  assign outs_b = {b_pc, b_ifw, b_idw, b_exw, b_iff, b_idf, b_exf};

  // {pc, IF/ID we, ID/EX we, EX/MEM we, IF/ID fl, ID/EX fl, EX/MEM fl}
  localparam logic [6:0] DEF = 7'b1111000;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] LUS = 7'b0011010;
  localparam logic [6:0] FLS = 7'b1111111;

  int checks = 0;
  int errors = 0;

  // Behavioural model: "frozen" while memory waits, a branch replay owed,
  // a branch remembered during the freeze, and raw event counts.
  bit m_frozen, m_replay, m_branch_seen;
  int m_lu, m_fl, m_wt;

  pipe_ctrl #(.CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
    .branch_taken_i(br), .mem_busy_i(busy),
    .pc_write_o(a_pc), .IF_IDwrite_o(a_ifw), .ID_EXwrite_o(a_idw),
    .EX_MEMwrite_o(a_exw), .IF_IDflush_o(a_iff), .ID_EXflush_o(a_idf),
    .EX_MEMflush_o(a_exf), .state_o(a_st),
    .lu_cnt_o(a_lu), .flush_cnt_o(a_fl), .wait_cnt_o(a_wt)
  );

  pipe_ctrl #(.CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
    .branch_taken_i(br), .mem_busy_i(busy),
    .pc_write_o(b_pc), .IF_IDwrite_o(b_ifw), .ID_EXwrite_o(b_idw),
    .EX_MEMwrite_o(b_exw), .IF_IDflush_o(b_iff), .ID_EXflush_o(b_idf),
    .EX_MEMflush_o(b_exf), .state_o(b_st),
    .lu_cnt_o(b_lu), .flush_cnt_o(b_fl), .wait_cnt_o(b_wt)
  );

  always #5 clk = ~clk;

  function automatic bit lu_ref();
    return ex_memread && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  function automatic logic [6:0] model_outs();
    if (!rst_n)   return FRZ;
    if (m_frozen) return FRZ;
    if (m_replay) return FLS;
    if (busy)     return FRZ;
    if (br)       return FLS;
    if (lu_ref()) return LUS;
    return DEF;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_frozen) return 2'd1;
    if (m_replay) return 2'd2;
    return 2'd0;
  endfunction

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    if (!rst_n) begin
      m_frozen = 0; m_replay = 0; m_branch_seen = 0;
      m_lu = 0; m_fl = 0; m_wt = 0;
    end else if (m_frozen) begin
      m_wt++;
      if (br) m_branch_seen = 1;
      if (!busy) begin
        m_frozen = 0;
        m_replay = m_branch_seen;
      end
    end else if (m_replay) begin
      m_fl++;
      m_replay = 0;
      m_branch_seen = 0;
    end else if (busy) begin
      m_frozen = 1;
      m_branch_seen = br;
    end else if (br) begin
      m_fl++;
    end else if (lu_ref()) begin
      m_lu++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_in();
    rst_n = 1'b1; id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 0; ex_memread = 0; br = 0; busy = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 1'b0; busy = 1; br = 1; ex_memread = 1; ex_rt = 3; id_rs = 3;
    @(negedge clk);
    checks++;
    if (outs_a !== FRZ) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs_a, FRZ); end
    advance();
    @(negedge clk);
    checks++;
    if ({a_st, a_lu, a_fl, a_wt} !== 50'd0)
      begin errors++; $display("FAIL reset_state st=%0d lu=%0d fl=%0d wt=%0d exp all 0", a_st, a_lu, a_fl, a_wt); end
    $display("reset: outs=%b st=%0d", outs_a, a_st);
    advance();
    clear_in();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1; ex_rt = 8; id_rs = 8;
    @(negedge clk);
    checks++;
    if (outs_a !== LUS) begin errors++; $display("FAIL lu_stall got=%b exp=%b", outs_a, LUS); end
    $display("load_use: outs=%b", outs_a);
    advance();
    clear_in();
    @(negedge clk);
    checks += 2;
    if (outs_a !== DEF) begin errors++; $display("FAIL lu_after got=%b exp=%b", outs_a, DEF); end
    if (a_lu !== 16'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", a_lu); end
    $display("load_use next: outs=%b lu_cnt=%0d", outs_a, a_lu);
    advance();
  endtask

  task automatic test_rt_zero();
    do_reset();
    ex_memread = 1; ex_rt = 0; id_rs = 0;
    @(negedge clk);
    checks++;
    if (outs_a !== DEF) begin errors++; $display("FAIL zero_reg got=%b exp=%b", outs_a, DEF); end
    $display("rt_zero: $0 outs=%b", outs_a);
    advance();
    ex_rt = 9; id_rt = 9; id_rs = 1; id_uses_rt = 0;
    @(negedge clk);
    checks++;
    if (outs_a !== DEF) begin errors++; $display("FAIL rt_unused got=%b exp=%b", outs_a, DEF); end
    $display("rt_zero: rt unused outs=%b", outs_a);
    advance();
    id_uses_rt = 1;
    @(negedge clk);
    checks++;
    if (outs_a !== LUS) begin errors++; $display("FAIL rt_used got=%b exp=%b", outs_a, LUS); end
    $display("rt_zero: rt used outs=%b", outs_a);
    advance();
    clear_in();
  endtask

  task automatic test_branch_vs_lu();
    do_reset();
    ex_memread = 1; ex_rt = 8; id_rs = 8; br = 1;
    @(negedge clk);
    checks++;
    if (outs_a !== FLS) begin errors++; $display("FAIL br_vs_lu got=%b exp=%b", outs_a, FLS); end
    $display("branch_vs_lu: outs=%b", outs_a);
    advance();
    clear_in();
    @(negedge clk);
    checks += 2;
    if (a_fl !== 16'd1) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=1", a_fl); end
    if (a_lu !== 16'd0) begin errors++; $display("FAIL br_lu_cnt got=%0d exp=0", a_lu); end
    $display("branch_vs_lu: flush_cnt=%0d lu_cnt=%0d", a_fl, a_lu);
    advance();
  endtask

  task automatic test_mem_freeze();
    logic [6:0] exp_o [8] = '{FRZ, FRZ, FRZ, FRZ, FLS, FRZ, FRZ, DEF};
    logic [1:0] exp_s [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
    bit         busy_v[8] = '{1, 1, 1, 0, 1, 1, 0, 0};
    bit         br_v  [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      busy = busy_v[c]; br = br_v[c];
      @(negedge clk);
      checks += 2;
      if (outs_a !== exp_o[c]) begin errors++; $display("FAIL freeze_outs c=%0d got=%b exp=%b", c, outs_a, exp_o[c]); end
      if (a_st !== exp_s[c]) begin errors++; $display("FAIL freeze_state c=%0d got=%0d exp=%0d", c, a_st, exp_s[c]); end
      if (c == 4) begin
        checks++;
        if (a_wt !== 16'd3) begin errors++; $display("FAIL freeze_wait_cnt got=%0d exp=3", a_wt); end
      end
      $display("mem_freeze c=%0d busy=%b br=%b outs=%b st=%0d wt=%0d", c, busy, br, outs_a, a_st, a_wt);
      advance();
    end
    @(negedge clk);
    checks += 2;
    if (a_wt !== 16'd4) begin errors++; $display("FAIL freeze_wait_total got=%0d exp=4", a_wt); end
    if (a_fl !== 16'd1) begin errors++; $display("FAIL freeze_flush_cnt got=%0d exp=1", a_fl); end
    clear_in();
  endtask

  task automatic test_lu_after_wait();
    do_reset();
    ex_memread = 1; ex_rt = 5; id_rs = 5; busy = 1;
    @(negedge clk); advance();
    @(negedge clk); advance();
    busy = 0;
    @(negedge clk);
    checks++;
    if (outs_a !== FRZ) begin errors++; $display("FAIL luw_exit got=%b exp=%b", outs_a, FRZ); end
    advance();
    @(negedge clk);
    checks++;
    if (outs_a !== LUS) begin errors++; $display("FAIL luw_stall got=%b exp=%b", outs_a, LUS); end
    $display("lu_after_wait: outs=%b", outs_a);
    advance();
    clear_in();
    @(negedge clk);
    checks += 2;
    if (outs_a !== DEF) begin errors++; $display("FAIL luw_after got=%b exp=%b", outs_a, DEF); end
    if (a_lu !== 16'd1) begin errors++; $display("FAIL luw_cnt got=%0d exp=1", a_lu); end
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_memread = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (outs_b !== LUS) begin errors++; $display("FAIL sat_stall k=%0d got=%b exp=%b", k, outs_b, LUS); end
      advance();
    end
    clear_in();
    @(negedge clk);
    checks += 2;
    if (b_lu !== 2'd3) begin errors++; $display("FAIL sat_lu_cnt got=%0d exp=3", b_lu); end
    if (a_lu !== 16'd5) begin errors++; $display("FAIL sat_wide_cnt got=%0d exp=5", a_lu); end
    $display("saturation: cnt2=%0d cnt16=%0d", b_lu, a_lu);
    advance();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    busy = 1; br = 1;
    @(negedge clk); advance();
    br = 0;
    @(negedge clk);
    checks++;
    if (a_st !== 2'd1) begin errors++; $display("FAIL rmw_in_wait got=%0d exp=1", a_st); end
    advance();
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (outs_a !== FRZ) begin errors++; $display("FAIL rmw_outs got=%b exp=%b", outs_a, FRZ); end
    advance();
    @(negedge clk);
    checks++;
    if (a_st !== 2'd0) begin errors++; $display("FAIL rmw_state got=%0d exp=0", a_st); end
    clear_in();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks += 2;
      if (outs_a !== DEF) begin errors++; $display("FAIL rmw_release k=%0d got=%b exp=%b", k, outs_a, DEF); end
      if (a_st !== 2'd0) begin errors++; $display("FAIL rmw_release_st k=%0d got=%0d exp=0", k, a_st); end
      $display("reset_mid_wait k=%0d outs=%b st=%0d", k, outs_a, a_st);
      advance();
    end
    @(negedge clk);
    checks++;
    if (a_fl !== 16'd0) begin errors++; $display("FAIL rmw_flush_cnt got=%0d exp=0", a_fl); end
  endtask

  task automatic test_random();
    logic [6:0]  eo;
    logic [1:0]  es;
    logic [47:0] ea;
    logic [5:0]  eb;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 99) >= 3);
      busy       = ($urandom_range(0, 99) < 20);
      br         = ($urandom_range(0, 99) < 15);
      ex_memread = ($urandom_range(0, 99) < 45);
      ex_rt      = 5'($urandom_range(0, 3));
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      @(negedge clk);
      eo = model_outs();
      es = model_state();
      ea = {16'(sat(m_lu, 16)), 16'(sat(m_fl, 16)), 16'(sat(m_wt, 16))};
      eb = {2'(sat(m_lu, 2)), 2'(sat(m_fl, 2)), 2'(sat(m_wt, 2))};
      checks += 6;
      if (outs_a !== eo) begin errors++; $display("FAIL rand_outs_a i=%0d got=%b exp=%b", i, outs_a, eo); end
      if (outs_b !== eo) begin errors++; $display("FAIL rand_outs_b i=%0d got=%b exp=%b", i, outs_b, eo); end
      if (a_st !== es) begin errors++; $display("FAIL rand_state_a i=%0d got=%0d exp=%0d", i, a_st, es); end
      if (b_st !== es) begin errors++; $display("FAIL rand_state_b i=%0d got=%0d exp=%0d", i, b_st, es); end
      if ({a_lu, a_fl, a_wt} !== ea)
        begin errors++; $display("FAIL rand_cnt_a i=%0d got=%h exp=%h", i, {a_lu, a_fl, a_wt}, ea); end
      if ({b_lu, b_fl, b_wt} !== eb)
        begin errors++; $display("FAIL rand_cnt_b i=%0d got=%h exp=%h", i, {b_lu, b_fl, b_wt}, eb); end
      $display("txn %0d rst=%b busy=%b br=%b lu=%b outs=%b st=%0d cnt=%0d/%0d/%0d",
               i, rst_n, busy, br, lu_ref(), outs_a, a_st, a_lu, a_fl, a_wt);
      advance();
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_load_use();
    test_rt_zero();
    test_branch_vs_lu();
    test_mem_freeze();
    test_lu_after_wait();
    test_saturation();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
